// File: rtl/sort4_seq_pkg.sv
// Shared state encoding and the fixed compare-and-swap schedule for sort4_seq.
package sort4_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] LAST_STEP = 3'd5;

    // Bubble-sort pass schedule: (0,1) (1,2) (2,3) (0,1) (1,2) (0,1)
    function automatic logic [1:0] pair_left(input logic [2:0] step);
        logic [1:0] idx;
        case (step)
            3'd0:    idx = 2'd0;
            3'd1:    idx = 2'd1;
            3'd2:    idx = 2'd2;
            3'd3:    idx = 2'd0;
            3'd4:    idx = 2'd1;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [1:0] pair_right(input logic [2:0] step);
        logic [1:0] idx;
        case (step)
            3'd0:    idx = 2'd1;
            3'd1:    idx = 2'd2;
            3'd2:    idx = 2'd3;
            3'd3:    idx = 2'd1;
            3'd4:    idx = 2'd2;
            default: idx = 2'd1;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/sort4_cmp.sv
// The block's single magnitude comparator: flags when a pair is out of order.
module sort4_cmp #(
    parameter int W       = 4,
    parameter int DESCEND = 0
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         swap
);

    // Strict compare so equal words stay put and the sort remains stable.
    generate
        if (DESCEND != 0) begin : g_desc
            assign swap = (a < b);
        end else begin : g_asc
            assign swap = (a > b);
        end
    endgenerate

endmodule

// File: rtl/sort4_seq.sv
// Four-word sequential sorter: six compare-and-swap steps through one shared comparator.
module sort4_seq
    import sort4_seq_pkg::*;
#(
    parameter int W       = 4,
    parameter int DESCEND = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] din0,
    input  logic [W-1:0] din1,
    input  logic [W-1:0] din2,
    input  logic [W-1:0] din3,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] dout0,
    output logic [W-1:0] dout1,
    output logic [W-1:0] dout2,
    output logic [W-1:0] dout3,
    output logic [2:0]   swaps
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          r_step;
    logic [2:0]          r_cnt;
    logic [3:0][W-1:0]   r_w;
    logic [3:0][W-1:0]   r_dout;
    logic [2:0]          r_swaps;

    logic [1:0]          w_li;
    logic [1:0]          w_ri;
    logic [W-1:0]        w_a;
    logic [W-1:0]        w_b;
    logic                w_swap;
    logic [3:0][W-1:0]   w_w_nxt;
    logic [2:0]          w_cnt_nxt;
    logic                w_accept;
    logic                w_last;

    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_state == S_RUN) && (r_step == LAST_STEP);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (r_step == LAST_STEP) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    assign w_li = pair_left(r_step);
    assign w_ri = pair_right(r_step);
    assign w_a  = r_w[w_li];
    assign w_b  = r_w[w_ri];

    sort4_cmp #(.W(W), .DESCEND(DESCEND)) u_cmp (
        .a    (w_a),
        .b    (w_b),
        .swap (w_swap)
    );

    always_comb begin
        w_w_nxt = r_w;
        if (w_swap) begin
            w_w_nxt[w_li] = w_b;
            w_w_nxt[w_ri] = w_a;
        end
        w_cnt_nxt = r_cnt + {2'b00, w_swap};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step  <= '0;
            r_cnt   <= '0;
            r_w     <= '0;
            r_dout  <= '0;
            r_swaps <= '0;
        end else if (w_accept) begin
            r_w    <= {din3, din2, din1, din0};
            r_step <= '0;
            r_cnt  <= '0;
        end else if (r_state == S_RUN) begin
            r_w    <= w_w_nxt;
            r_cnt  <= w_cnt_nxt;
            r_step <= w_last ? 3'd0 : r_step + 3'd1;
            // Result registers change only here, so no partial sort is ever visible.
            if (w_last) begin
                r_dout  <= w_w_nxt;
                r_swaps <= w_cnt_nxt;
            end
        end
    end

    assign busy  = (r_state == S_RUN);
    assign done  = (r_state == S_DONE);
    assign dout0 = r_dout[0];
    assign dout1 = r_dout[1];
    assign dout2 = r_dout[2];
    assign dout3 = r_dout[3];
    assign swaps = r_swaps;

endmodule

// File: tb/tb_sort4_seq.sv
// Randomized self-checking bench for sort4_seq; ascending and descending instances share inputs.
module tb_sort4_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] din0, din1, din2, din3;

    logic       a_busy, a_done, d_busy, d_done;
    logic [3:0] a_o0, a_o1, a_o2, a_o3, d_o0, d_o1, d_o2, d_o3;
    logic [2:0] a_sw, d_sw;

    int n_chk;
    int n_fail;
    int pa[4];
    int pd[4];
    int psa, psd;

    sort4_seq #(.W(4), .DESCEND(0)) u_asc (
        .clk(clk), .rst_n(rst_n), .start(start),
        .din0(din0), .din1(din1), .din2(din2), .din3(din3),
        .busy(a_busy), .done(a_done),
        .dout0(a_o0), .dout1(a_o1), .dout2(a_o2), .dout3(a_o3),
        .swaps(a_sw)
    );

    sort4_seq #(.W(4), .DESCEND(1)) u_desc (
        .clk(clk), .rst_n(rst_n), .start(start),
        .din0(din0), .din1(din1), .din2(din2), .din3(din3),
        .busy(d_busy), .done(d_done),
        .dout0(d_o0), .dout1(d_o1), .dout2(d_o2), .dout3(d_o3),
        .swaps(d_sw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: sorted order plus inversion count (a full bubble sort swaps once per inversion).
    task automatic model(input int v0, input int v1, input int v2, input int v3, input bit desc,
                         output int s0, output int s1, output int s2, output int s3, output int inv);
        int v[4];
        int t;
        v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
        inv = 0;
        for (int i = 0; i < 4; i++)
            for (int j = i + 1; j < 4; j++)
                if (desc ? (v[i] < v[j]) : (v[i] > v[j])) inv++;
        for (int i = 0; i < 4; i++)
            for (int j = i + 1; j < 4; j++)
                if (desc ? (v[j] > v[i]) : (v[j] < v[i])) begin
                    t = v[i]; v[i] = v[j]; v[j] = t;
                end
        s0 = v[0]; s1 = v[1]; s2 = v[2]; s3 = v[3];
    endtask

    task automatic chk_hold(input string tag);
        chk({tag, "_a_d0"}, a_o0, pa[0]);
        chk({tag, "_a_d1"}, a_o1, pa[1]);
        chk({tag, "_a_d2"}, a_o2, pa[2]);
        chk({tag, "_a_d3"}, a_o3, pa[3]);
        chk({tag, "_a_sw"}, a_sw, psa);
        chk({tag, "_d_d0"}, d_o0, pd[0]);
        chk({tag, "_d_d1"}, d_o1, pd[1]);
        chk({tag, "_d_d2"}, d_o2, pd[2]);
        chk({tag, "_d_d3"}, d_o3, pd[3]);
        chk({tag, "_d_sw"}, d_sw, psd);
    endtask

    task automatic chk_idle(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); @(negedge clk);
            chk({tag, "_busy"}, {a_busy, d_busy}, 2'b00);
            chk({tag, "_done"}, {a_done, d_done}, 2'b00);
        end
    endtask

    // Entered and left at a falling edge; the exit point is the done cycle.
    task automatic do_sort(input string tag, input int v0, input int v1, input int v2, input int v3,
                           input bit mid_pulse);
        int s0, s1, s2, s3, inv;
        din0 = v0[3:0]; din1 = v1[3:0]; din2 = v2[3:0]; din3 = v3[3:0];
        start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        din0 = 4'($urandom); din1 = 4'($urandom); din2 = 4'($urandom); din3 = 4'($urandom);
        for (int i = 0; i < 6; i++) begin
            chk({tag, "_run_busy"}, {a_busy, d_busy}, 2'b11);
            chk({tag, "_run_done"}, {a_done, d_done}, 2'b00);
            chk_hold({tag, "_run"});
            start = (mid_pulse && i == 2);
            if (i < 5) begin
                @(posedge clk); @(negedge clk);
            end
        end
        start = 1'b0;
        @(posedge clk); @(negedge clk);
        chk({tag, "_done"}, {a_done, d_done}, 2'b11);
        chk({tag, "_busy0"}, {a_busy, d_busy}, 2'b00);
        model(v0, v1, v2, v3, 1'b0, s0, s1, s2, s3, inv);
        pa[0] = s0; pa[1] = s1; pa[2] = s2; pa[3] = s3; psa = inv;
        model(v0, v1, v2, v3, 1'b1, s0, s1, s2, s3, inv);
        pd[0] = s0; pd[1] = s1; pd[2] = s2; pd[3] = s3; psd = inv;
        chk_hold({tag, "_res"});
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        pa = '{0, 0, 0, 0}; pd = '{0, 0, 0, 0}; psa = 0; psd = 0;
        start = 1'b0; din0 = '0; din1 = '0; din2 = '0; din3 = '0;
        rst_n = 1'b0;
        #2;
        chk("rst_busy", {a_busy, d_busy}, 2'b00);
        chk("rst_done", {a_done, d_done}, 2'b00);
        chk_hold("rst");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        chk_idle("idle", 10);

        // Directed cases; the descending instance checks the same inputs in parallel.
        @(negedge clk);
        do_sort("near", 3, 10, 15, 14, 1'b0);
        chk("near_swaps_lit", a_sw, 1);
        chk_idle("near_after", 1);
        @(negedge clk);
        do_sort("rev", 15, 14, 5, 1, 1'b0);
        chk("rev_swaps_lit", a_sw, 6);
        chk("rev_desc_swaps_lit", d_sw, 0);
        chk("rev_desc_d0_lit", d_o0, 15);
        chk_idle("rev_after", 1);
        @(negedge clk);
        do_sort("dup", 15, 15, 1, 1, 1'b0);
        chk("dup_swaps_lit", a_sw, 4);
        chk_idle("dup_after", 1);
        @(negedge clk);
        do_sort("eq", 5, 5, 5, 5, 1'b0);
        chk("eq_swaps_lit", {a_sw, d_sw}, 6'd0);
        chk_idle("eq_after", 1);

        // Start mid-run is ignored, then back-to-back start during done.
        @(negedge clk);
        do_sort("ign", 9, 2, 7, 0, 1'b1);
        do_sort("b2b", 12, 3, 8, 5, 1'b0);
        chk("b2b_a_d0_lit", a_o0, 3);
        chk("b2b_a_sw_lit", a_sw, 4);
        chk_idle("b2b_after", 2);

        // Reset during step 2.
        @(negedge clk);
        din0 = 4'd14; din1 = 4'd3; din2 = 4'd11; din3 = 4'd15;
        start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b0;
        #1;
        pa = '{0, 0, 0, 0}; pd = '{0, 0, 0, 0}; psa = 0; psd = 0;
        chk("mrst_busy", {a_busy, d_busy}, 2'b00);
        chk("mrst_done", {a_done, d_done}, 2'b00);
        chk_hold("mrst");
        @(negedge clk);
        rst_n = 1'b1;
        chk_idle("mrst_idle", 8);
        chk_hold("mrst_after");
        @(negedge clk);
        do_sort("post", 8, 5, 9, 1, 1'b0);
        chk("post_sw_lit", a_sw, 4);
        chk_idle("post_after", 1);

        // Random transactions, some chained back-to-back.
        @(negedge clk);
        for (int t = 0; t < 24; t++) begin
            do_sort("rnd", int'($urandom_range(15)), int'($urandom_range(15)),
                    int'($urandom_range(15)), int'($urandom_range(15)), ($urandom_range(3) == 0));
            if ($urandom_range(1) == 0) begin
                chk_idle("rnd_gap", 1);
                @(negedge clk);
            end
        end
        chk_idle("final", 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
